// File: rtl/sdcard_spi.sv
// sdcard_spi: byte-wide SPI master (mode 0) for the SD card pins of PORTB.
// The CPU writes SPDR to start a transfer; the byte is shifted out MSB-first
// on mosi while miso is shifted in, then spif is raised.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   data_out[7:0]  register read data (combinational, 0 unless cs&&oe&&!rst)
//   data_in[7:0]   register write data
//   addr[5:0]      register address (00 SPDR, 01 SPSR, 02 SPDIV)
//   cs, oe, we     block select, read strobe, write strobe
//   sck, mosi      SPI clock and data out
//   miso           SPI data in (asynchronous, synchronised internally)
module sdcard_spi #(
    parameter logic [7:0] RESET_DIV = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    input  logic [5:0] addr,
    input  logic       cs,
    input  logic       oe,
    input  logic       we,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t      state, state_n;
    logic        sck_n, mosi_n;
    logic [7:0]  tx, tx_n;
    logic [6:0]  shift, shift_n;
    logic [7:0]  rx, rx_n;
    logic        spif, spif_n;
    logic        wcol, wcol_n;
    logic [7:0]  spdiv, spdiv_n;
    logic [7:0]  cnt, cnt_n;
    logic [2:0]  bitcnt, bitcnt_n;
    logic [2:0]  tx_idx;
    logic        miso_s;
    logic        spif_set;

    logic wr_spdr, rd_spdr, wr_div, busy;

    assign wr_spdr = cs && we && (addr == 6'h00);
    assign rd_spdr = cs && oe && (addr == 6'h00);
    assign wr_div  = cs && we && (addr == 6'h02);
    assign busy    = (state != IDLE);
    // Next bit to present after the current falling edge; wraps to 7 on the
    // last bit, where mosi is forced back to idle-high anyway.
    assign tx_idx  = 3'd6 - bitcnt;

    always_comb begin
        data_out = 8'h00;
        if (cs && oe && !rst) begin
            case (addr)
                6'h00:   data_out = rx;
                6'h01:   data_out = {spif, wcol, busy, 5'b0};
                6'h02:   data_out = spdiv;
                default: data_out = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_n  = state;
        sck_n    = sck;
        mosi_n   = mosi;
        tx_n     = tx;
        shift_n  = shift;
        rx_n     = rx;
        cnt_n    = cnt;
        bitcnt_n = bitcnt;
        spif_set = 1'b0;
        // A divider write only affects the next reload; the running phase
        // keeps counting down from the value already loaded in cnt.
        spdiv_n  = wr_div ? data_in : spdiv;

        case (state)
            IDLE: begin
                sck_n  = 1'b0;
                mosi_n = 1'b1;
                if (wr_spdr) begin
                    tx_n     = data_in;
                    mosi_n   = data_in[7];
                    cnt_n    = spdiv;
                    bitcnt_n = 3'd0;
                    state_n  = LOW;
                end
            end
            LOW: begin
                if (cnt == 8'd0) begin
                    sck_n   = 1'b1;
                    cnt_n   = spdiv;
                    state_n = HIGH;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            HIGH: begin
                if (cnt == 8'd0) begin
                    // miso is sampled at the end of the high phase, which
                    // hides the one-cycle synchroniser latency.
                    sck_n    = 1'b0;
                    shift_n  = {shift[5:0], miso_s};
                    mosi_n   = tx[tx_idx];
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        rx_n     = {shift, miso_s};
                        spif_set = 1'b1;
                        mosi_n   = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        cnt_n   = spdiv;
                        state_n = LOW;
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Setting a flag takes priority over the read-to-clear.
        spif_n = spif_set ? 1'b1 : (rd_spdr ? 1'b0 : spif);
        wcol_n = (wr_spdr && busy) ? 1'b1 : (rd_spdr ? 1'b0 : wcol);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sck    <= 1'b0;
            mosi   <= 1'b1;
            tx     <= 8'h00;
            shift  <= 7'h00;
            rx     <= 8'h00;
            spif   <= 1'b0;
            wcol   <= 1'b0;
            spdiv  <= RESET_DIV;
            cnt    <= 8'h00;
            bitcnt <= 3'd0;
            miso_s <= 1'b1;
        end else begin
            state  <= state_n;
            sck    <= sck_n;
            mosi   <= mosi_n;
            tx     <= tx_n;
            shift  <= shift_n;
            rx     <= rx_n;
            spif   <= spif_n;
            wcol   <= wcol_n;
            spdiv  <= spdiv_n;
            cnt    <= cnt_n;
            bitcnt <= bitcnt_n;
            miso_s <= miso;
        end
    end

endmodule

// File: tb/tb_sdcard_spi.sv
module tb_sdcard_spi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_out;
    logic [7:0] data_in = 8'h00;
    logic [5:0] addr = 6'h00;
    logic       cs = 1'b0;
    logic       oe = 1'b0;
    logic       we = 1'b0;
    logic       sck, mosi, miso;
    logic       loop = 1'b1;
    logic       miso_fix = 1'b0;

    assign miso = loop ? mosi : miso_fix;

    sdcard_spi dut (
        .clk      (clk),
        .rst      (rst),
        .data_out (data_out),
        .data_in  (data_in),
        .addr     (addr),
        .cs       (cs),
        .oe       (oe),
        .we       (we),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] exp;
        string      name;
    } rd_t;

    rd_t        rdq[$];
    logic [7:0] txq[$];

    // Read monitor: every strobed read is matched against the next queued expectation.
    always @(negedge clk) begin
        rd_t e;
        #2;
        if (cs && oe && !rst) begin
            if (rdq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got %0h expected no read", data_out);
            end else begin
                e = rdq.pop_front();
                chk(e.name, data_out, e.exp);
            end
        end
    end

    // SPI monitor: assemble mosi at each sck rise and match whole bytes.
    logic [7:0] sh = 8'h00;
    int nb = 0;
    int rises = 0;
    always @(posedge sck or posedge rst) begin
        if (rst) begin
            nb = 0;
            txq.delete();
        end else begin
            sh = {sh[6:0], mosi};
            nb++;
            rises++;
            if (nb == 8) begin
                nb = 0;
                if (txq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mosi_unexpected: got %0h expected no byte", sh);
                end else begin
                    chk("mosi_byte", sh, txq.pop_front());
                end
            end
        end
    end

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] e, input string name);
        rd_t r;
        r.exp = e;
        r.name = name;
        rdq.push_back(r);
        cs = 1'b1; oe = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; oe = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, r0, werr;
        logic exp_sck;

        repeat (2) @(negedge clk);
        cs = 1'b1; oe = 1'b1; addr = 6'h02;
        #1 chk("dout_in_reset", data_out, 8'h00);
        cs = 1'b0; oe = 1'b0;
        chk("sck_reset", sck, 0);
        chk("mosi_reset", mosi, 1);
        rst = 1'b0;
        @(negedge clk);
        rd(6'h01, 8'h00, "spsr_reset");
        rd(6'h02, 8'hFF, "spdiv_reset");
        rd(6'h00, 8'h00, "spdr_reset");
        rd(6'h05, 8'h00, "unmapped_read");
        wr(6'h07, 8'h55);
        rd(6'h02, 8'hFF, "spdiv_after_unmapped_wr");

        // Loopback, SPDIV=0
        loop = 1'b1;
        wr(6'h02, 8'h00);
        rd(6'h02, 8'h00, "spdiv_wr");
        r0 = rises;
        txq.push_back(8'hA5);
        wr(6'h00, 8'hA5);
        t = cyc;
        wait_until(t + 15);
        rd(6'h01, 8'h20, "lb_busy_T15");
        rd(6'h01, 8'h80, "lb_spif_T16");
        rd(6'h00, 8'hA5, "lb_rx");
        rd(6'h01, 8'h00, "lb_spsr_clr");
        chk("lb_pulses", rises - r0, 8);

        // Fixed miso=0, SPDIV=3: check the sck waveform cycle by cycle
        loop = 1'b0;
        miso_fix = 1'b0;
        wr(6'h02, 8'h03);
        txq.push_back(8'hFF);
        wr(6'h00, 8'hFF);
        t = cyc;
        werr = 0;
        for (int k = 0; k < 64; k++) begin
            exp_sck = ((k / 4) % 2) == 1;
            if (sck !== exp_sck || mosi !== 1'b1) werr++;
            if (k == 0) rd(6'h01, 8'h20, "d3_busy_T1");
            else if (k == 63) rd(6'h01, 8'h20, "d3_busy_T63");
            else @(negedge clk);
        end
        chk("d3_wave_errors", werr, 0);
        chk("d3_sck_done", sck, 0);
        rd(6'h01, 8'h80, "d3_spif_T64");
        rd(6'h00, 8'h00, "d3_rx");
        rd(6'h01, 8'h00, "d3_spsr_clr");

        // Collision, SPDIV=0
        loop = 1'b1;
        wr(6'h02, 8'h00);
        txq.push_back(8'h3C);
        wr(6'h00, 8'h3C);
        t = cyc;
        wait_until(t + 4);
        wr(6'h00, 8'h99);
        rd(6'h01, 8'h60, "col_spsr");
        wait_until(t + 16);
        rd(6'h01, 8'hC0, "col_done");
        rd(6'h00, 8'h3C, "col_rx");
        rd(6'h01, 8'h00, "col_clr");

        // SPDR read in the completion cycle: set wins
        txq.push_back(8'h5A);
        wr(6'h00, 8'h5A);
        t = cyc;
        wait_until(t + 15);
        rd(6'h00, 8'h3C, "sim_old_rx");
        rd(6'h01, 8'h80, "sim_spif_kept");
        rd(6'h00, 8'h5A, "sim_rx");
        rd(6'h01, 8'h00, "sim_clr");

        // Async reset mid-transfer
        txq.push_back(8'hC3);
        wr(6'h00, 8'hC3);
        t = cyc;
        wait_until(t + 7);
        chk("pre_rst_sck", sck, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_sck_async", sck, 0);
        chk("rst_mosi_async", mosi, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(6'h01, 8'h00, "rst_spsr");
        rd(6'h02, 8'hFF, "rst_spdiv");
        rd(6'h00, 8'h00, "rst_rx");

        // New transfer after reset, SPDIV=1
        wr(6'h02, 8'h01);
        txq.push_back(8'h81);
        wr(6'h00, 8'h81);
        t = cyc;
        wait_until(t + 31);
        rd(6'h01, 8'h20, "post_busy_T31");
        rd(6'h01, 8'h80, "post_spif_T32");
        rd(6'h00, 8'h81, "post_rx");
        rd(6'h01, 8'h00, "post_clr");

        repeat (3) @(negedge clk);
        chk("txq_drained", txq.size(), 0);
        chk("rdq_drained", rdq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
